axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
Round-robin, packet-locked arbiter that shares one downstream AXI-Stream channel (e.g. the summing core) among PAR_NUM_PORTS upstream requesters. A port holds the grant from its first accepted beat through its tlast beat. The block then rotates priority. Output is fully registered through a 2-entry skid buffer, so m_axis_* carries no combinational path from s_axis_* or from m_axis_tready.

Parameters:
PAR_WDATA_BYTE, 2, data bus width in bytes (1..2)
PAR_NUM_PORTS, 4, number of slave ports (2..8)
PAR_ID_W, $clog2(PAR_NUM_PORTS), width of m_axis_tid (derived; not overridden)

Ports:
aclk  in  1  clock
aresetn  in  1  reset: synchronous, active-low; clock aclk
s_axis_tdata  in  PAR_NUM_PORTS*8*PAR_WDATA_BYTE  packed per-port data; port i at slice i
s_axis_tvalid  in  PAR_NUM_PORTS  per-port valid
s_axis_tlast  in  PAR_NUM_PORTS  per-port end of packet
s_axis_tready  out  PAR_NUM_PORTS  per-port ready; at most one bit high
m_axis_tdata  out  8*PAR_WDATA_BYTE  arbitrated data
m_axis_tlast  out  1  arbitrated tlast
m_axis_tid  out  PAR_ID_W  index of the source port of the current beat
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
grant  out  PAR_NUM_PORTS  one-hot current owner; 0 when idle

Behaviour:
- Reset values:
  - all outputs 0; m_axis_tvalid=0; s_axis_tready=0; grant=0.
  - FSM state IDLE; rotation pointer ptr=0; skid buffer empty.
- FSM IDLE:
  - If no tvalid bit is set, stay IDLE.
  - Otherwise select the first port i with s_axis_tvalid[i]=1, searching ptr, ptr+1, … mod PAR_NUM_PORTS.
  - Register grant=onehot(i) and go to BUSY.
  - No beat is accepted in the IDLE cycle.
- FSM BUSY, owner g:
  - s_axis_tready[g] = buffer has at least one free entry (registered flag). All other ready bits are 0.
  - A beat is accepted when tvalid[g] and tready[g] are both high. It is written with {tdata, tlast, tid=g}.
  - On acceptance of a beat with tlast=1: ptr <= (g+1) mod PAR_NUM_PORTS, grant <= 0, state <= IDLE.
  - tvalid[g] deasserting mid-packet holds the grant; the block waits indefinitely.
- Throughput: one bubble cycle (IDLE) between packets; otherwise 1 beat/cycle.
- Latency: a beat accepted at edge k is visible on m_axis_* after edge k, i.e. during cycle k+1 when the buffer was empty.
- Skid buffer:
  - Depth 2; outputs come from the head entry.
  - m_axis_tready=0 holds m_axis_tdata/tlast/tid/tvalid stable.
  - With m_axis_tready=1 and an entry present, the head pops each cycle.
  - Full (2 entries): tready[g]=0 on the next cycle.
  - Simultaneous push and pop with 1 entry keeps occupancy at 1.
- Fairness: a port requesting continuously waits at most PAR_NUM_PORTS-1 packets.
- Wrap-around: ptr after port PAR_NUM_PORTS-1 is 0.
- Inputs from non-granted ports are ignored; their tready stays 0.
- Reset mid-packet: synchronous reset discards the buffer contents and the in-progress packet. The downstream receives a truncated packet without tlast; this is accepted behaviour.
- Data is never modified; tlast and tid travel with their beat.

Test Plan:
- Single beat: port 2 sends 0x1234, tlast=1, from reset → m_axis_tdata=0x1234, tid=2, tlast=1; tvalid rises 2 cycles after s_tvalid; ptr=3.
- Contention: ports 0, 1, 3 each send a 1-beat packet at the same cycle, m_tready=1 → output tid order 0,1,3, one idle cycle between beats, grant one-hot each time.
- Packet lock: port 1 sends a 4-beat packet 0xA0..0xA3 while port 0 requests → all four port-1 beats are contiguous; port 0 data appears only after beat 0xA3 with tlast.
- Backpressure: m_tready held 0 for 5 cycles during a 4-beat packet → exactly 2 beats buffered, s_tready[g]=0 after the second, m_tdata stable; after release all beats arrive in order with no loss or duplication.
- Wrap: ptr=3 with all ports requesting → port 3 is granted first, then 0, 1, 2.
- Reset mid-packet: aresetn low for 1 cycle after beat 2 of 4 → next cycle all outputs 0 and grant=0; a fresh port-0 packet is then arbitrated normally with ptr=0.

Source files
------------

// File: rtl/axis_rr_arbiter_if.sv
// rtl/axis_rr_arbiter_if.sv - bundled upstream/downstream stream signals for the round-robin arbiter
interface axis_rr_arbiter_if #(
  parameter int PAR_WDATA_BYTE = 2,
  parameter int PAR_NUM_PORTS  = 4
);
  localparam int PAR_ID_W = $clog2(PAR_NUM_PORTS);
  localparam int DW       = 8 * PAR_WDATA_BYTE;

  logic [PAR_NUM_PORTS*DW-1:0] s_axis_tdata;
  logic [PAR_NUM_PORTS-1:0]    s_axis_tvalid;
  logic [PAR_NUM_PORTS-1:0]    s_axis_tlast;
  logic [PAR_NUM_PORTS-1:0]    s_axis_tready;
  logic [DW-1:0]               m_axis_tdata;
  logic                        m_axis_tlast;
  logic [PAR_ID_W-1:0]         m_axis_tid;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;
  logic [PAR_NUM_PORTS-1:0]    grant;

  // arbiter side: sinks the upstream ports, sources the shared downstream channel
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tvalid, grant
  );

  // environment side: drives requesters and the downstream ready
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tvalid, grant
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet-locked round-robin stream arbiter with registered 2-entry skid output
module axis_rr_arbiter #(
  parameter int PAR_WDATA_BYTE = 2,
  parameter int PAR_NUM_PORTS  = 4
) (
  input  logic               aclk,
  input  logic               aresetn,
  axis_rr_arbiter_if.slave   bus
);
  localparam int PAR_ID_W = $clog2(PAR_NUM_PORTS);
  localparam int DW       = 8 * PAR_WDATA_BYTE;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [PAR_ID_W-1:0]      ptr_q, ptr_d;
  logic [PAR_ID_W-1:0]      owner_q, owner_d;
  logic [PAR_NUM_PORTS-1:0] grant_q, grant_d;

  // skid buffer: entry 0 is always the head presented downstream
  logic [DW-1:0]            dat0_q, dat0_d, dat1_q, dat1_d;
  logic                     lst0_q, lst0_d, lst1_q, lst1_d;
  logic [PAR_ID_W-1:0]      id0_q, id0_d, id1_q, id1_d;
  logic [1:0]               cnt_q, cnt_d;

  logic                     free;
  logic                     accept;
  logic                     pop;
  logic [DW-1:0]            in_data;
  logic                     in_last;
  logic                     in_valid;
  logic                     sel_found;
  logic [PAR_ID_W-1:0]      sel_idx;
  logic [PAR_ID_W:0]        cand_sum;
  logic [PAR_ID_W-1:0]      cand;

  // free is derived from the occupancy register only, so ready never depends on m_axis_tready
  assign free   = ~cnt_q[1];
  assign pop    = (cnt_q != 2'd0) && bus.m_axis_tready;
  assign accept = (state_q == ST_BUSY) && in_valid && free;

  assign bus.s_axis_tready = grant_q & {PAR_NUM_PORTS{free}};
  assign bus.grant         = grant_q;
  assign bus.m_axis_tvalid = (cnt_q != 2'd0);
  assign bus.m_axis_tdata  = dat0_q;
  assign bus.m_axis_tlast  = lst0_q;
  assign bus.m_axis_tid    = id0_q;

  // mux the current owner's beat onto a single lane
  always_comb begin
    in_data  = '0;
    in_last  = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < PAR_NUM_PORTS; i++) begin
      if (owner_q == PAR_ID_W'(i)) begin
        in_data  = bus.s_axis_tdata[i*DW +: DW];
        in_last  = bus.s_axis_tlast[i];
        in_valid = bus.s_axis_tvalid[i];
      end
    end
  end

  // first requesting port searching upward from the rotation pointer, wrapping at PAR_NUM_PORTS
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < PAR_NUM_PORTS; k++) begin
      cand_sum = {1'b0, ptr_q} + (PAR_ID_W+1)'(k);
      if (cand_sum >= (PAR_ID_W+1)'(PAR_NUM_PORTS)) begin
        cand_sum = cand_sum - (PAR_ID_W+1)'(PAR_NUM_PORTS);
      end
      cand = cand_sum[PAR_ID_W-1:0];
      if (!sel_found && bus.s_axis_tvalid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // arbitration FSM: grant in IDLE, hold the owner until its tlast beat is taken
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    if (state_q == ST_IDLE) begin
      if (sel_found) begin
        owner_d = sel_idx;
        grant_d = PAR_NUM_PORTS'(1) << sel_idx;
        state_d = ST_BUSY;
      end
    end else if (accept && in_last) begin
      ptr_d   = (owner_q == PAR_ID_W'(PAR_NUM_PORTS-1)) ? '0 : owner_q + PAR_ID_W'(1);
      grant_d = '0;
      state_d = ST_IDLE;
    end
  end

  // skid buffer next state: shift on pop, write the new beat into the first free slot after the shift
  always_comb begin
    dat0_d = dat0_q;
    lst0_d = lst0_q;
    id0_d  = id0_q;
    dat1_d = dat1_q;
    lst1_d = lst1_q;
    id1_d  = id1_q;
    if (pop) begin
      dat0_d = dat1_q;
      lst0_d = lst1_q;
      id0_d  = id1_q;
    end
    if (accept) begin
      if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) begin
        dat0_d = in_data;
        lst0_d = in_last;
        id0_d  = owner_q;
      end else begin
        dat1_d = in_data;
        lst1_d = in_last;
        id1_d  = owner_q;
      end
    end
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // arbitration registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
    end
  end

  // skid buffer registers; reset drops any buffered beats
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      dat0_q <= '0;
      lst0_q <= 1'b0;
      id0_q  <= '0;
      dat1_q <= '0;
      lst1_q <= 1'b0;
      id1_q  <= '0;
      cnt_q  <= 2'd0;
    end else begin
      dat0_q <= dat0_d;
      lst0_q <= lst0_d;
      id0_q  <= id0_d;
      dat1_q <= dat1_d;
      lst1_q <= lst1_d;
      id1_q  <= id1_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - scoreboard bench for the round-robin stream arbiter
module tb_axis_rr_arbiter;
  localparam int B   = 2;
  localparam int N   = 4;
  localparam int DW  = 8 * B;
  localparam int IDW = 2;

  typedef logic [DW+IDW:0] beat_t;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axis_rr_arbiter_if #(.PAR_WDATA_BYTE(B), .PAR_NUM_PORTS(N)) bus ();

  axis_rr_arbiter #(.PAR_WDATA_BYTE(B), .PAR_NUM_PORTS(N)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  beat_t exp_q[$];
  int    pop_cyc[$];
  int    cyc    = 0;
  int    n_chk  = 0;
  int    n_fail = 0;
  int    sent[N];

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [DW-1:0] d, input logic l, input int id);
    return {d, l, IDW'(id)};
  endfunction

  // monitor: every downstream transfer is popped against the expected queue
  initial begin
    beat_t got;
    beat_t e;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        check("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        check("tready_onehot0", 32'($onehot0(bus.s_axis_tready)), 32'd1);
      end
      if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
        got = {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tid};
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(got), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'(got), 32'(e));
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic send_pkt(input int p, input logic [DW-1:0] d0, input int len);
    logic ok;
    int   t;
    for (int b = 0; b < len; b++) begin
      bus.s_axis_tdata[p*DW +: DW] = d0 + DW'(b);
      bus.s_axis_tvalid[p] = 1'b1;
      bus.s_axis_tlast[p]  = (b == len - 1);
      ok = 1'b0;
      t  = 0;
      while (!ok && t < 200) begin
        @(negedge aclk);
        ok = bus.s_axis_tready[p];
        @(posedge aclk);
        #1;
        t++;
      end
      if (!ok) check("send_timeout", 32'd0, 32'd1);
      else sent[p]++;
    end
    bus.s_axis_tvalid[p] = 1'b0;
    bus.s_axis_tlast[p]  = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.m_axis_tvalid) && t < 300) begin
      @(posedge aclk);
      #1;
      t++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int   t;
    int   acc;
    logic ok;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++) sent[i] = 0;

    // reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("rst_s_tready", 32'(bus.s_axis_tready), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_m_tdata", 32'(bus.m_axis_tdata), 32'd0);
    check("rst_m_tid_tlast", 32'({bus.m_axis_tid, bus.m_axis_tlast}), 32'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // single beat from port 2: grant one cycle later, output two cycles later
    exp_q.push_back(mk(16'h1234, 1'b1, 2));
    fork send_pkt(2, 16'h1234, 1); join_none
    @(negedge aclk);
    check("single_lat0_valid", 32'(bus.m_axis_tvalid), 32'd0);
    check("single_lat0_grant", 32'(bus.grant), 32'd0);
    @(negedge aclk);
    check("single_lat1_valid", 32'(bus.m_axis_tvalid), 32'd0);
    check("single_lat1_grant", 32'(bus.grant), 32'b0100);
    @(negedge aclk);
    check("single_lat2_valid", 32'(bus.m_axis_tvalid), 32'd1);
    check("single_lat2_tid", 32'(bus.m_axis_tid), 32'd2);
    wait_drain("single_drain");
    wait fork;
    check("single_ptr", 32'(dut.ptr_q), 32'd3);

    // contention: ports 0,1,3 from ptr=0, one bubble between packets
    do_reset();
    pop_cyc.delete();
    exp_q.push_back(mk(16'h1000, 1'b1, 0));
    exp_q.push_back(mk(16'h1001, 1'b1, 1));
    exp_q.push_back(mk(16'h1003, 1'b1, 3));
    fork
      send_pkt(0, 16'h1000, 1);
      send_pkt(1, 16'h1001, 1);
      send_pkt(3, 16'h1003, 1);
    join_none
    wait_drain("cont_drain");
    wait fork;
    check("cont_count", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("cont_gap01", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
      check("cont_gap12", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);
    end

    // packet lock: port 1 four beats, port 0 requests mid-packet
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(16'h00A0 + 16'(i), i == 3, 1));
    exp_q.push_back(mk(16'h00B0, 1'b1, 0));
    fork
      send_pkt(1, 16'h00A0, 4);
      begin
        repeat (3) @(posedge aclk);
        #1;
        send_pkt(0, 16'h00B0, 1);
      end
    join_none
    wait_drain("lock_drain");
    wait fork;
    check("lock_ptr", 32'(dut.ptr_q), 32'd1);

    // backpressure: downstream stalled, only two beats may be taken
    bus.m_axis_tready = 1'b0;
    sent[2] = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(16'h00C0 + 16'(i), i == 3, 2));
    fork send_pkt(2, 16'h00C0, 4); join_none
    t = 0;
    @(negedge aclk);
    while (!bus.m_axis_tvalid && t < 50) begin
      @(negedge aclk);
      t++;
    end
    check("bp_valid", 32'(bus.m_axis_tvalid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("bp_hold_data", 32'(bus.m_axis_tdata), 32'h00C0);
      check("bp_hold_valid", 32'(bus.m_axis_tvalid), 32'd1);
    end
    check("bp_accepted", 32'(sent[2]), 32'd2);
    check("bp_s_tready", 32'(bus.s_axis_tready), 32'd0);
    @(posedge aclk);
    #1;
    bus.m_axis_tready = 1'b1;
    wait_drain("bp_drain");
    wait fork;

    // wrap: ptr=3, all ports request
    exp_q.push_back(mk(16'h3003, 1'b1, 3));
    exp_q.push_back(mk(16'h3000, 1'b1, 0));
    exp_q.push_back(mk(16'h3001, 1'b1, 1));
    exp_q.push_back(mk(16'h3002, 1'b1, 2));
    fork
      send_pkt(0, 16'h3000, 1);
      send_pkt(1, 16'h3001, 1);
      send_pkt(2, 16'h3002, 1);
      send_pkt(3, 16'h3003, 1);
    join_none
    wait_drain("wrap_drain");
    wait fork;

    // reset after beat 2 of a 4-beat packet from port 3
    exp_q.push_back(mk(16'h00D0, 1'b0, 3));
    exp_q.push_back(mk(16'h00D1, 1'b0, 3));
    bus.s_axis_tdata[3*DW +: DW] = 16'h00D0;
    bus.s_axis_tvalid[3] = 1'b1;
    bus.s_axis_tlast[3]  = 1'b0;
    acc = 0;
    t   = 0;
    while (acc < 2 && t < 100) begin
      @(negedge aclk);
      ok = bus.s_axis_tready[3];
      @(posedge aclk);
      #1;
      t++;
      if (ok) begin
        acc++;
        bus.s_axis_tdata[3*DW +: DW] = 16'h00D0 + 16'(acc);
      end
    end
    check("mid_accepts", 32'(acc), 32'd2);
    aresetn = 1'b0;
    bus.s_axis_tvalid[3] = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("mid_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("mid_grant", 32'(bus.grant), 32'd0);
    check("mid_s_tready", 32'(bus.s_axis_tready), 32'd0);
    check("mid_m_outs", 32'({bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tid}), 32'd0);
    check("mid_trunc_seen", 32'(exp_q.size()), 32'd0);
    check("mid_ptr", 32'(dut.ptr_q), 32'd0);
    exp_q.push_back(mk(16'h00E0, 1'b1, 0));
    send_pkt(0, 16'h00E0, 1);
    wait_drain("post_rst_drain");

    repeat (3) @(posedge aclk);
    check("final_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
